// File: rtl/hdmi_packet_scheduler.sv
// Frames HDMI data islands (preamble, guards, 32-cycle packets) in blanking; round-robin grants to NUM_SRC sources.
// Ack is combinational on the last lead-guard/packet cycle, framing decodes registered state; SCHED_PRIO0_EN gives source 0 priority.
module hdmi_packet_scheduler #(
    parameter int NUM_SRC     = 4,
    parameter int MAX_PACKETS = 18,
    parameter int CTRL_GAP    = 12,
    parameter int TAIL_MARGIN = 12
) (
    input  logic                     clk_pixel,
    input  logic                     reset,
    input  logic                     blank,
    input  logic [11:0]              blank_remaining,
    input  logic [NUM_SRC-1:0]       req,
    input  logic [24*NUM_SRC-1:0]    src_header,
    input  logic [224*NUM_SRC-1:0]   src_sub,
    output logic [NUM_SRC-1:0]       ack,
    output logic [23:0]              header,
    output logic [223:0]             sub,
    output logic                     data_island_period,
    output logic                     di_preamble,
    output logic                     di_guard,
    output logic [4:0]               pkt_in_island
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [11:0] FIRST_NEED = 12'(8 + 2 + 32 + 2 + TAIL_MARGIN);
    localparam logic [11:0] NEXT_NEED  = 12'(32 + 2 + TAIL_MARGIN);
    localparam logic [11:0] GAP_LAST   = 12'(CTRL_GAP - 1);
    localparam logic [4:0]  MAX_PKT    = 5'(MAX_PACKETS);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_SRC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_PREAMBLE,
        S_LEAD_GUARD,
        S_PACKET,
        S_TRAIL_GUARD
    } state_t;

    state_t            state, state_nxt;
    logic [4:0]        phase, phase_nxt;
    logic [11:0]       gap_cnt, gap_cnt_nxt;
    logic [PTR_W-1:0]  rr_ptr;
    logic              island_done;
    logic [PTR_W-1:0]  win_idx;
    logic              win_vld;
    logic              grant_slot;
    logic              more_ok;
    logic              grant;
    logic              island_go;

    logic [23:0]       hdr_arr [NUM_SRC];
    logic [223:0]      sub_arr [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign hdr_arr[i] = src_header[24*i +: 24];
        assign sub_arr[i] = src_sub[224*i +: 224];
    end

    // Winner search starts at rr_ptr; with priority, source 0 bypasses the rotation.
    always_comb begin
        logic [PTR_W-1:0] cidx;
        int               start;
        int               cand;
        win_vld = 1'b0;
        win_idx = '0;
        cidx    = '0;
        cand    = 0;
        start   = int'(rr_ptr);
`ifdef SCHED_PRIO0_EN
        if (start == 0) start = 1;
        if (req[0]) begin
            win_vld = 1'b1;
        end else begin
            for (int j = 0; j < NUM_SRC - 1; j++) begin
                cand = 1 + ((start - 1 + j) % (NUM_SRC - 1));
                cidx = PTR_W'(cand);
                if (!win_vld && req[cidx]) begin
                    win_vld = 1'b1;
                    win_idx = cidx;
                end
            end
        end
`else
        for (int j = 0; j < NUM_SRC; j++) begin
            cand = (start + j) % NUM_SRC;
            cidx = PTR_W'(cand);
            if (!win_vld && req[cidx]) begin
                win_vld = 1'b1;
                win_idx = cidx;
            end
        end
`endif
    end

    assign grant_slot = ((state == S_LEAD_GUARD) && (phase == 5'd1)) ||
                        ((state == S_PACKET) && (phase == 5'd31));
    assign more_ok    = (state == S_LEAD_GUARD) ||
                        ((pkt_in_island < MAX_PKT) && (blank_remaining >= NEXT_NEED));
    assign grant      = grant_slot && more_ok && win_vld && blank && !reset;

    // gap_cnt counts control cycles already elapsed, so this is the CTRL_GAP-th one.
    assign island_go  = (gap_cnt == GAP_LAST) && (|req) && !island_done &&
                        (blank_remaining >= FIRST_NEED);

    always_comb begin
        ack = '0;
        for (int i = 0; i < NUM_SRC; i++)
            ack[i] = grant && (win_idx == PTR_W'(i));
    end

    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase;
        gap_cnt_nxt = gap_cnt;
        if (!blank) begin
            state_nxt   = S_IDLE;
            phase_nxt   = '0;
            gap_cnt_nxt = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!island_done) begin
                        state_nxt   = S_GAP;
                        gap_cnt_nxt = 12'd1;
                    end
                    phase_nxt = '0;
                end
                S_GAP: begin
                    if (island_go) begin
                        state_nxt = S_PREAMBLE;
                        phase_nxt = '0;
                    end else if (gap_cnt != 12'hFFF) begin
                        gap_cnt_nxt = gap_cnt + 12'd1;
                    end
                end
                S_PREAMBLE: begin
                    if (phase == 5'd7) begin
                        state_nxt = S_LEAD_GUARD;
                        phase_nxt = '0;
                    end else begin
                        phase_nxt = phase + 5'd1;
                    end
                end
                S_LEAD_GUARD, S_PACKET: begin
                    if (grant_slot) begin
                        state_nxt = grant ? S_PACKET : S_TRAIL_GUARD;
                        phase_nxt = '0;
                    end else begin
                        phase_nxt = phase + 5'd1;
                    end
                end
                S_TRAIL_GUARD: begin
                    if (phase == 5'd1) begin
                        state_nxt = S_IDLE;
                        phase_nxt = '0;
                    end else begin
                        phase_nxt = phase + 5'd1;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    phase_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state         <= S_IDLE;
            phase         <= '0;
            gap_cnt       <= '0;
            rr_ptr        <= '0;
            island_done   <= 1'b0;
            header        <= '0;
            sub           <= '0;
            pkt_in_island <= '0;
        end else begin
            state   <= state_nxt;
            phase   <= phase_nxt;
            gap_cnt <= gap_cnt_nxt;
            if (!blank) begin
                island_done   <= 1'b0;
                header        <= '0;
                sub           <= '0;
                pkt_in_island <= '0;
            end else begin
                if ((state == S_GAP) && island_go) begin
                    island_done   <= 1'b1;
                    pkt_in_island <= '0;
                end
                if (grant) begin
                    header        <= hdr_arr[win_idx];
                    sub           <= sub_arr[win_idx];
                    pkt_in_island <= pkt_in_island + 5'd1;
                    rr_ptr        <= (win_idx == LAST_IDX) ? '0 : win_idx + PTR_W'(1);
                end
            end
        end
    end

    assign di_preamble        = (state == S_PREAMBLE);
    assign di_guard           = (state == S_LEAD_GUARD) || (state == S_TRAIL_GUARD);
    assign data_island_period = (state == S_PACKET);

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// Scoreboard bench for hdmi_packet_scheduler: a schedule model predicts grants and framing tallies per blanking interval.
`timescale 1ns/1ps
module tb_hdmi_packet_scheduler;

    localparam int N    = 4;
    localparam int MAXP = 18;
    localparam int TAIL = 12;

    logic               clk_pixel = 1'b0;
    logic               reset;
    logic               blank;
    logic [11:0]        blank_remaining;
    logic [N-1:0]       req;
    logic [24*N-1:0]    src_header;
    logic [224*N-1:0]   src_sub;
    logic [N-1:0]       ack;
    logic [23:0]        header;
    logic [223:0]       sub;
    logic               data_island_period;
    logic               di_preamble;
    logic               di_guard;
    logic [4:0]         pkt_in_island;

    hdmi_packet_scheduler #(.NUM_SRC(N), .MAX_PACKETS(MAXP), .CTRL_GAP(12), .TAIL_MARGIN(TAIL)) dut (
        .clk_pixel(clk_pixel), .reset(reset), .blank(blank), .blank_remaining(blank_remaining),
        .req(req), .src_header(src_header), .src_sub(src_sub), .ack(ack), .header(header), .sub(sub),
        .data_island_period(data_island_period), .di_preamble(di_preamble), .di_guard(di_guard),
        .pkt_in_island(pkt_in_island)
    );

    always #5 clk_pixel = ~clk_pixel;

    int cyc = 0;
    always @(posedge clk_pixel) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        logic [N-1:0] ack;
        logic [23:0]  hdr;
        logic [223:0] sub;
    } exp_t;

    // kinds: 0 pkt_in_island, 1 all-zero outputs, 2 preamble cycles, 3 guard cycles,
    // 4 packet cycles, 5 first preamble cycle, 6 no grants outstanding (clears tallies)
    typedef struct {
        int cyc;
        int kind;
        int val;
    } chk_t;

    exp_t sb[$];
    chk_t pq[$];

    int checks = 0;
    int errors = 0;

    logic [23:0]  hdr_tab [N][8];
    logic [223:0] sub_tab [N][8];
    int           need [N];
    int           sent [N];
    int           rr = 0;

    // ---------------- monitor ----------------
    int   pre_n = 0, grd_n = 0, dip_n = 0, first_pre = -1;
    bit   hdr_due = 0;
    exp_t hdr_exp;

    always @(negedge clk_pixel) begin
        exp_t e;
        chk_t c;
        int   obs;
        if (di_preamble) begin
            pre_n++;
            if (first_pre < 0) first_pre = cyc;
        end
        if (di_guard) grd_n++;
        if (data_island_period) dip_n++;

        if (hdr_due) begin
            hdr_due = 0;
            checks++;
            if (header !== hdr_exp.hdr || sub !== hdr_exp.sub || data_island_period !== 1'b1) begin
                errors++;
                $display("FAIL latch cyc=%0d header=%h want=%h dip=%b sub=%h want=%h",
                         cyc, header, hdr_exp.hdr, data_island_period, sub, hdr_exp.sub);
            end
        end

        if (ack !== '0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL ack cyc=%0d got=%b want=none", cyc, ack);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || e.ack !== ack) begin
                    errors++;
                    $display("FAIL ack cyc=%0d got=%b want=%b at cyc %0d", cyc, ack, e.ack, e.cyc);
                end
                hdr_exp = e;
                hdr_due = 1;
            end
        end

        while (pq.size() > 0 && pq[0].cyc <= cyc) begin
            c = pq.pop_front();
            checks++;
            case (c.kind)
                0: obs = int'(pkt_in_island);
                1: obs = (ack == '0 && header == '0 && sub == '0 && !data_island_period &&
                          !di_preamble && !di_guard && pkt_in_island == '0) ? 0 : 1;
                2: obs = pre_n;
                3: obs = grd_n;
                4: obs = dip_n;
                5: obs = first_pre;
                default: obs = sb.size();
            endcase
            if (obs != c.val || c.cyc != cyc) begin
                errors++;
                $display("FAIL kind%0d cyc=%0d got=%0d want=%0d", c.kind, cyc, obs, c.val);
            end
            if (c.kind == 6) begin
                pre_n = 0; grd_n = 0; dip_n = 0; first_pre = -1;
            end
        end
    end

    // ---------------- reference schedule ----------------
    function automatic int pick(input int av[N], input int p);
`ifdef SCHED_PRIO0_EN
        int q;
        if (av[0] > 0) return 0;
        q = (p == 0) ? 1 : p;
        for (int j = 0; j < N - 1; j++)
            if (av[1 + ((q - 1 + j) % (N - 1))] > 0) return 1 + ((q - 1 + j) % (N - 1));
`else
        for (int j = 0; j < N; j++)
            if (av[(p + j) % N] > 0) return (p + j) % N;
`endif
        return -1;
    endfunction

    function automatic void push_chk(input int c, input int k, input int v);
        chk_t x;
        x.cyc = c; x.kind = k; x.val = v;
        pq.push_back(x);
    endfunction

    // L: blank_remaining at blank rise; A: cycle blank is forced low (-1 none); R: reset cycle (-1 none)
    task automatic run_scn(input int L, input int A, input int R);
        int   end_blank, T, S, stop, g, w, npk, total;
        int   avail [N];
        bit   island;
        exp_t e;
        end_blank = (A >= 0) ? A : L;
        T = end_blank + 6;
        for (int i = 0; i < N; i++) begin
            sent[i] = 0;
            for (int k = 0; k < 8; k++) begin
                hdr_tab[i][k] = 24'($urandom);
                sub_tab[i][k] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            end
        end
        S = cyc;

        stop = end_blank;
        if (R >= 0 && R < stop) stop = R;
        total = 0;
        for (int i = 0; i < N; i++) begin
            avail[i] = need[i];
            total += need[i];
        end
        npk = 0;
        island = 0;
        if (total > 0 && L - 11 >= 44 + TAIL && stop > 11) begin
            island = 1;
            g = 21;
            while (g < stop) begin
                w = pick(avail, rr);
                if (w < 0) break;
                if (npk > 0 && (npk >= MAXP || L - g < 32 + 2 + TAIL)) break;
                e.cyc = S + g;
                e.ack = '0;
                e.ack[w] = 1'b1;
                e.hdr = hdr_tab[w][need[w] - avail[w]];
                e.sub = sub_tab[w][need[w] - avail[w]];
                sb.push_back(e);
                avail[w]--;
                rr = (w + 1) % N;
                npk++;
                g += 32;
            end
        end
        if (R >= 0) rr = 0;

        if (A < 0 && R < 0) begin
            push_chk(S + L - 1, 0, npk);
            push_chk(S + T - 1, 5, island ? S + 12 : -1);
            push_chk(S + T - 1, 2, island ? 8 : 0);
            push_chk(S + T - 1, 3, island ? 4 : 0);
            push_chk(S + T - 1, 4, 32 * npk);
        end else begin
            if (R >= 0) push_chk(S + R + 1, 1, 0);
            if (A >= 0 && !(R >= 0 && A == R + 1)) push_chk(S + A + 1, 1, 0);
            else if (A >= 0) push_chk(S + A + 1, 1, 0);
        end
        push_chk(S + T - 1, 6, 0);

        for (int t = 0; t < T; t++) begin
            reset = (t == R);
            blank = (t < end_blank);
            blank_remaining = blank ? 12'(L - t) : 12'd0;
            for (int i = 0; i < N; i++) begin
                req[i] = (sent[i] < need[i]);
                src_header[24*i +: 24]  = hdr_tab[i][(sent[i] < 8) ? sent[i] : 7];
                src_sub[224*i +: 224]   = sub_tab[i][(sent[i] < 8) ? sent[i] : 7];
            end
            @(negedge clk_pixel);
            for (int i = 0; i < N; i++)
                if (ack[i]) sent[i]++;
            @(posedge clk_pixel);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic set_need(input int a, input int b, input int c, input int d);
        need[0] = a; need[1] = b; need[2] = c; need[3] = d;
    endtask

    initial begin
        reset = 1'b1;
        blank = 1'b1;
        blank_remaining = 12'd500;
        req = '1;
        src_header = '1;
        src_sub = '1;
        repeat (3) @(posedge clk_pixel);
        #1;
        push_chk(cyc, 1, 0);
        @(posedge clk_pixel);
        #1;
        reset = 1'b0;
        blank = 1'b0;
        req = '0;
        repeat (4) @(posedge clk_pixel);
        #1;
        push_chk(cyc, 6, 0);
        @(posedge clk_pixel);
        #1;

        set_need(1, 0, 0, 0); run_scn(100, -1, -1);
        set_need(1, 1, 1, 0); run_scn(300, -1, -1);
        set_need(1, 0, 0, 0); run_scn(50, -1, -1);
        set_need(1, 1, 1, 1); run_scn(90, -1, -1);
        set_need(5, 5, 5, 5); run_scn(800, -1, -1);
        set_need(1, 1, 0, 0); run_scn(200, 30, -1);
        set_need(1, 1, 1, 1); run_scn(200, 26, 25);
        set_need(1, 1, 1, 0); run_scn(300, -1, -1);
        set_need(3, 1, 0, 1); run_scn(200, -1, -1);
        set_need(1, 1, 0, 1); run_scn(200, -1, -1);

        for (int s = 0; s < 20; s++) begin
            int L, A;
            L = int'($urandom_range(40, 600));
            A = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, L - 1)) : -1;
            set_need(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            run_scn(L, A, -1);
        end

        repeat (3) @(posedge clk_pixel);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
